// File: rtl/etc_pkg.sv
// Shared types and helpers for the Extended Tensor Core semiring tile.
// Operation and FSM encodings plus the per-operation accumulator identity.
package etc_pkg;

  typedef enum logic [1:0] {
    ETC_MAC     = 2'd0,
    ETC_MINPLUS = 2'd1,
    ETC_MAXPLUS = 2'd2,
    ETC_L2D     = 2'd3
  } etc_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } etc_state_e;

  localparam int ETC_MAX_AW = 128;

  // MINPLUS starts from all-ones so the first slice always wins the min.
  function automatic logic [ETC_MAX_AW-1:0] etc_identity(input etc_op_e op, input int aw);
    logic [ETC_MAX_AW-1:0] ones;
    ones = {ETC_MAX_AW{1'b1}} >> (ETC_MAX_AW - aw);
    return (op == ETC_MINPLUS) ? ones : '0;
  endfunction

endpackage

// File: rtl/etc_pe.sv
// One output element of the semiring tile: reduces a row/column pair and combines into acc.
// Optional macro ETC_SAT_EN makes MAC/L2D accumulation saturate instead of wrapping.
module etc_pe
  import etc_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int AW = 32
) (
  input  logic [N-1:0][W-1:0] i_aRow,
  input  logic [N-1:0][W-1:0] i_bCol,
  input  etc_op_e             i_op,
  input  logic                i_first,
  input  logic [AW-1:0]       i_accIn,
  output logic [AW-1:0]       o_accOut,
  output logic                o_sat
);

  localparam int SW = 2*W + $clog2(N) + 1;
`ifdef ETC_SAT_EN
  localparam int XW = ((AW > SW) ? AW : SW) + 1;
`else
  localparam int XW = AW;
`endif

  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_absDiff;
  logic [2*W-1:0] w_sq;
  logic [AW-1:0]  w_pair;
  logic [SW-1:0]  w_sliceSum;
  logic [AW-1:0]  w_sliceMin;
  logic [AW-1:0]  w_sliceMax;
  logic [AW-1:0]  w_base;
  logic [XW-1:0]  w_wide;

  // The squared difference only needs |A-B|, which keeps the square exact in 2W bits.
  always_comb begin
    w_prod     = '0;
    w_absDiff  = '0;
    w_sq       = '0;
    w_pair     = '0;
    w_sliceSum = '0;
    w_sliceMin = '1;
    w_sliceMax = '0;
    for (int k = 0; k < N; k++) begin
      w_prod    = (2*W)'(i_aRow[k]) * (2*W)'(i_bCol[k]);
      w_absDiff = (i_aRow[k] >= i_bCol[k]) ? (i_aRow[k] - i_bCol[k]) : (i_bCol[k] - i_aRow[k]);
      w_sq      = (2*W)'(w_absDiff) * (2*W)'(w_absDiff);
      w_pair    = AW'(i_aRow[k]) + AW'(i_bCol[k]);
      if (i_op == ETC_L2D) w_sliceSum = w_sliceSum + SW'(w_sq);
      else                 w_sliceSum = w_sliceSum + SW'(w_prod);
      if (w_pair < w_sliceMin) w_sliceMin = w_pair;
      if (w_pair > w_sliceMax) w_sliceMax = w_pair;
    end
  end

  always_comb begin
    w_base   = i_first ? AW'(etc_identity(i_op, AW)) : i_accIn;
    w_wide   = XW'(w_base) + XW'(w_sliceSum);
    o_accOut = w_wide[AW-1:0];
    o_sat    = 1'b0;
    case (i_op)
      ETC_MINPLUS: o_accOut = (w_sliceMin < w_base) ? w_sliceMin : w_base;
      ETC_MAXPLUS: o_accOut = (w_sliceMax > w_base) ? w_sliceMax : w_base;
      default: begin
`ifdef ETC_SAT_EN
        if (w_wide > XW'({AW{1'b1}})) begin
          o_accOut = '1;
          o_sat    = 1'b1;
        end
`endif
      end
    endcase
  end

endmodule

// File: rtl/etc_semiring_tile.sv
// N x N semiring tensor tile: two-stage operand pipeline, accumulator array and result handshake.
// Optional macro ETC_SAT_EN enables saturating MAC/L2D accumulation and the sticky out_sat flag.
module etc_semiring_tile
  import etc_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int AW = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  op,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [N-1:0][N-1:0][W-1:0]  inA,
  input  logic [N-1:0][N-1:0][W-1:0]  inB,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N-1:0][N-1:0][AW-1:0] out,
  output logic                        out_sat
);

  etc_state_e                  r_state;
  logic                        r_inReady;
  logic                        r_outValid;
  logic                        r_s0Valid;
  logic                        r_s0First;
  logic                        r_s0Last;
  etc_op_e                     r_s0Op;
  logic [N-1:0][N-1:0][W-1:0]  r_s0A;
  logic [N-1:0][N-1:0][W-1:0]  r_s0B;
  logic                        r_s1Last;
  logic [N-1:0][N-1:0][AW-1:0] r_acc;
  logic                        r_sat;

  logic                        w_accept;
  logic                        w_openTile;
  logic [N-1:0][N-1:0][W-1:0]  w_bT;
  logic [N-1:0][N-1:0][AW-1:0] w_accNext;
  logic [N-1:0][N-1:0]         w_peSat;

  assign w_accept   = in_valid & r_inReady;
  assign w_openTile = in_first | (r_state == IDLE);

  for (genvar gj = 0; gj < N; gj++) begin : g_bT
    for (genvar gk = 0; gk < N; gk++) begin : g_k
      assign w_bT[gj][gk] = r_s0B[gk][gj];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      etc_pe #(.N(N), .W(W), .AW(AW)) u_pe (
        .i_aRow   (r_s0A[gi]),
        .i_bCol   (w_bT[gj]),
        .i_op     (r_s0Op),
        .i_first  (r_s0First),
        .i_accIn  (r_acc[gi][gj]),
        .o_accOut (w_accNext[gi][gj]),
        .o_sat    (w_peSat[gi][gj])
      );
    end
  end

  // Stage0 captures the accepted beat; the following edge folds it into the accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0Valid <= 1'b0;
      r_s0First <= 1'b0;
      r_s0Last  <= 1'b0;
      r_s0Op    <= ETC_MAC;
      r_s0A     <= '0;
      r_s0B     <= '0;
      r_s1Last  <= 1'b0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_s0Valid <= w_accept;
      r_s1Last  <= r_s0Valid & r_s0Last;
      if (w_accept) begin
        r_s0A     <= inA;
        r_s0B     <= inB;
        r_s0Last  <= in_last;
        r_s0First <= w_openTile;
        if (w_openTile) r_s0Op <= etc_op_e'(op);
      end
      if (r_s0Valid) begin
        r_acc <= w_accNext;
        r_sat <= (r_s0First ? 1'b0 : r_sat) | (|w_peSat);
      end
    end
  end

  // DRAIN is entered as soon as the closing beat is accepted so no further beats slip in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_state <= ACCUM;
            if (in_last) begin
              r_state   <= DRAIN;
              r_inReady <= 1'b0;
            end
          end
        end
        DRAIN: begin
          r_inReady <= 1'b0;
          if (r_s1Last) r_outValid <= 1'b1;
          if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b0;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out       = r_acc;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_etc_semiring_tile.sv
// Self-checking bench for etc_semiring_tile against a plain-arithmetic semiring model.
// Expected saturation behaviour follows whether ETC_SAT_EN is defined for the build.
module tb_etc_semiring_tile;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 32;

  typedef logic [N-1:0][N-1:0][W-1:0]  slice_t;
  typedef logic [N-1:0][N-1:0][AW-1:0] res_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   [1:0] op = 2'd0;
  logic   in_valid = 1'b0;
  logic   in_ready;
  logic   in_first = 1'b0;
  logic   in_last = 1'b0;
  slice_t inA = '0;
  slice_t inB = '0;
  logic   out_valid;
  logic   out_ready = 1'b0;
  res_t   out;
  logic   out_sat;

  int nTests = 0;
  int nFail  = 0;

  slice_t     tA[8];
  slice_t     tB[8];
  logic       tFirst[8];
  logic [1:0] tOp[8];

  always #5 clk = ~clk;

  etc_semiring_tile #(.N(N), .W(W), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .inA       (inA),
    .inB       (inB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_sat   (out_sat)
  );

  // Semiring product evaluated element by element straight from the operation definitions.
  function automatic void modelTile(input int nb, output res_t eo, output logic es);
    longint unsigned maxv, acc, s, t, av, bv;
    longint d;
    int o;
    logic sat;
    maxv = (64'd1 << AW) - 64'd1;
    eo = '0;
    es = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0; sat = 1'b0; o = 0;
        for (int b = 0; b < nb; b++) begin
          if (b == 0 || tFirst[b]) begin
            o = int'(tOp[b]);
            acc = (o == 1) ? maxv : 64'd0;
            sat = 1'b0;
          end
          s = 0;
          for (int k = 0; k < N; k++) begin
            av = 64'(tA[b][i][k]);
            bv = 64'(tB[b][k][j]);
            t  = av + bv;
            d  = longint'(av) - longint'(bv);
            case (o)
              0: s = s + av * bv;
              1: if (k == 0 || t < s) s = t;
              2: if (k == 0 || t > s) s = t;
              default: s = s + longint'(d * d);
            endcase
          end
          if (o == 1)      acc = (s < acc) ? s : acc;
          else if (o == 2) acc = (s > acc) ? s : acc;
          else begin
            acc = acc + s;
            if (acc > maxv) begin
`ifdef ETC_SAT_EN
              acc = maxv;
              sat = 1'b1;
`else
              acc = acc & maxv;
`endif
            end
          end
        end
        eo[i][j] = acc[AW-1:0];
        es = es | sat;
      end
    end
  endfunction

  function automatic logic [W-1:0] randVal();
    case ($urandom_range(0, 3))
      0:       return W'($urandom);
      1:       return {W{1'b1}};
      default: return W'($urandom_range(0, 300));
    endcase
  endfunction

  task automatic clearTile();
    for (int b = 0; b < 8; b++) begin
      tA[b] = '0; tB[b] = '0; tFirst[b] = 1'b0; tOp[b] = 2'd0;
    end
  endtask

  task automatic randomBeat(input int b);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        tA[b][i][k] = randVal();
        tB[b][i][k] = randVal();
      end
  endtask

  // Drives the prepared beats back to back, then checks latency, result, hold and handshake.
  task automatic run_tile(input int nb, input int hold, input string name);
    res_t eo;
    logic es;
    modelTile(nb, eo, es);
    for (int b = 0; b < nb; b++) begin
      in_valid  = 1'b1;
      in_first  = (b == 0) || tFirst[b];
      in_last   = (b == nb - 1);
      inA       = tA[b];
      inB       = tB[b];
      op        = in_first ? tOp[b] : 2'($urandom);
      out_ready = 1'($urandom);
      nTests++;
      if (in_ready !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL %s beat%0d in_ready: got %b want 1", name, b, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    nTests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL %s closing: got in_ready=%b out_valid=%b want 0 0", name, in_ready, out_valid);
    end
    @(posedge clk); #1;
    nTests++;
    if (out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL %s early_valid: got %b want 0", name, out_valid);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    nTests++;
    if (out_valid !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s latency: out_valid got %b want 1", name, out_valid);
    end
    nTests++;
    if (out !== eo) begin
      nFail++;
      $display("[TB] FAIL %s result: got %h want %h", name, out, eo);
    end
    nTests++;
    if (out_sat !== es) begin
      nFail++;
      $display("[TB] FAIL %s out_sat: got %b want %b", name, out_sat, es);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      nTests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== eo) begin
        nFail++;
        $display("[TB] FAIL %s hold%0d: got valid=%b ready=%b out=%h want 1 0 %h",
                 name, h, out_valid, in_ready, out, eo);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nTests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL %s handshake: got valid=%b ready=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nTests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out !== '0 || out_sat !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_state: got ready=%b valid=%b sat=%b out=%h want 0 0 0 0",
               in_ready, out_valid, out_sat, out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    nTests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_release: got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_identity();
    logic ok;
    clearTile();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        tA[0][i][k] = (i == k) ? W'(1) : W'(0);
        tB[0][i][k] = W'(i * 4 + k);
      end
    run_tile(1, 0, "identity");
    ok = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (out[i][j] !== AW'(i * 4 + j)) ok = 1'b0;
    nTests++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL identity_equals_B: got %h", out);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    clearTile();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          tA[b][i][k] = W'(1);
          tB[b][i][k] = W'(2);
        end
    run_tile(3, 0, "mac_b2b");
    ok = 1'b1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (out[i][j] !== AW'(24)) ok = 1'b0;
    nTests++;
    if (!ok) begin
      nFail++;
      $display("[TB] FAIL mac_b2b_24: got %h want all 24", out);
    end
  endtask

  task automatic test_minmax();
    logic ok;
    for (int m = 1; m <= 2; m++) begin
      clearTile();
      for (int b = 0; b < 2; b++) begin
        tOp[b] = 2'(m);
        for (int i = 0; i < N; i++)
          for (int k = 0; k < N; k++) begin
            tA[b][i][k] = W'(k);
            tB[b][k][i] = W'(10 - k);
          end
      end
      run_tile(2, 0, (m == 1) ? "minplus" : "maxplus");
      ok = 1'b1;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (out[i][j] !== AW'(10)) ok = 1'b0;
      nTests++;
      if (!ok) begin
        nFail++;
        $display("[TB] FAIL op%0d_all10: got %h want all 10", m, out);
      end
    end
  endtask

  task automatic test_l2d();
    clearTile();
    randomBeat(0);
    tOp[0] = 2'd3;
    for (int k = 0; k < N; k++) begin
      tA[0][0][k] = W'((k < 3) ? k + 1 : 0);
      tB[0][k][1] = W'((k < 3) ? 4 + 2 * k : 0);
      tB[0][k][0] = tA[0][0][k];
    end
    run_tile(1, 0, "l2d");
    nTests++;
    if (out[0][1] !== AW'(50) || out[0][0] !== AW'(0)) begin
      nFail++;
      $display("[TB] FAIL l2d_spot: got [0][1]=%0d [0][0]=%0d want 50 0", out[0][1], out[0][0]);
    end
  endtask

  task automatic test_hold_and_reset();
    clearTile();
    randomBeat(0);
    randomBeat(1);
    tOp[0] = 2'd0;
    run_tile(2, 5, "hold5");
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; in_first = (b == 0); in_last = 1'b0;
      inA = slice_t'({N*N{W'($urandom)}}); inB = inA; op = 2'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    nTests++;
    if (out_valid !== 1'b0 || out !== '0 || in_ready !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL mid_reset: got valid=%b ready=%b out=%h want 0 0 0", out_valid, in_ready, out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    clearTile();
    randomBeat(0);
    randomBeat(1);
    tOp[0] = 2'd3;
    run_tile(2, 1, "after_reset");
  endtask

  task automatic test_saturation();
    clearTile();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          tA[b][i][k] = {W{1'b1}};
          tB[b][i][k] = {W{1'b1}};
        end
    run_tile(2, 0, "sat");
    nTests++;
`ifdef ETC_SAT_EN
    if (out[2][3] !== 32'hFFFFFFFF || out_sat !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL sat_value: got %h sat=%b want ffffffff 1", out[2][3], out_sat);
    end
`else
    if (out[2][3] !== 32'hFFF00008 || out_sat !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL wrap_value: got %h sat=%b want fff00008 0", out[2][3], out_sat);
    end
`endif
    clearTile();
    randomBeat(0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) tA[0][i][k] = W'(k);
    run_tile(1, 0, "sat_cleared");
  endtask

  task automatic test_random();
    int nb;
    for (int t = 0; t < 25; t++) begin
      clearTile();
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        randomBeat(b);
        tOp[b]    = 2'($urandom);
        tFirst[b] = (b > 0) && ($urandom_range(0, 3) == 0);
      end
      run_tile(nb, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_minmax();
    test_l2d();
    test_hold_and_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
